conv_layer_ctrl: RTL and testbench

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

---
 rtl/conv_ctrl_pkg.sv | 20 ++
 rtl/handshake_watchdog.sv | 37 +++
 rtl/conv_layer_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_conv_layer_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared types and helpers for the conv layer controller
//
// Holds the controller state enum and the width function used to size the
// {conv index+1, kernel address} fields of the layer memory address.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eLOAD,
    eSTART,
    eRUN,
    eDONE
  } conv_ctrl_state_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int field_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/handshake_watchdog.sv
// rtl/handshake_watchdog.sv - idle-cycle watchdog for the layer output handshake
//
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   active_i       : count only while asserted (controller in eRUN)
//   clear_i        : restart the idle count (handshake seen or frame start)
//   expired_o      : high in the TIMEOUT_CYCLES-th consecutive idle active cycle
module handshake_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNTW-1:0] idle_cnt_q;

  // The count holds the number of idle cycles already spent, so the current
  // cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign expired_o = active_i && !clear_i &&
                     (idle_cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_cnt_q <= '0;
    end else if (clear_i || !active_i || expired_o) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + CNTW'(1);
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// rtl/conv_layer_ctrl.sv - weight loader and frame sequencer for a conv layer
//
// Optional watchdog: define CONV_CTRL_TIMEOUT_EN to abort a run that sees no
// layer output handshake for TIMEOUT_CYCLES cycles (timeout_o pulse).
//
// Ports:
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   load_i, run_i             : command pulses (only honoured in eIDLE)
//   run_frames_i              : frames per run, sampled with run_i (0 means 1)
//   cfg_valid_i/cfg_yumi_o/cfg_data_i : weight stream, consumed in eLOAD
//   layer_start_o             : one-cycle frame start pulse
//   layer_mem_addr_o          : {conv index+1, kernel address} during load
//   layer_wen_o/layer_mem_data_o : weight write strobe and data
//   layer_out_hs_i            : layer output handshake observed
//   loaded_o, busy_o          : status levels
//   done_o, err_o, timeout_o  : one-cycle status pulses
module conv_layer_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int N_CONVOLUTIONS     = 1,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int KERNEL_WIDTH       = 2,
  parameter int INPUT_LAYER_HEIGHT = 5,
  parameter int WORD_SIZE          = 16,
  parameter int FRAME_W            = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic [FRAME_W-1:0]   run_frames_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_yumi_o,
  input  logic [WORD_SIZE-1:0] cfg_data_i,
  output logic                 layer_start_o,
  output logic [field_w(N_CONVOLUTIONS)+field_w(KERNEL_HEIGHT*KERNEL_WIDTH)-1:0] layer_mem_addr_o,
  output logic                 layer_wen_o,
  output logic [WORD_SIZE-1:0] layer_mem_data_o,
  input  logic                 layer_out_hs_i,
  output logic                 loaded_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 timeout_o
);

  localparam int KS            = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int OUT_PER_FRAME = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
  localparam int CW            = field_w(N_CONVOLUTIONS);
  localparam int KW            = field_w(KS);
  localparam int OW            = field_w(OUT_PER_FRAME);

  conv_ctrl_state_e state_q, state_d;

  logic [CW-1:0]      conv_q;
  logic [KW-1:0]      kaddr_q;
  logic [OW-1:0]      out_cnt_q;
  logic [FRAME_W-1:0] frames_left_q;
  logic               loaded_q;
  logic               load_done_q;
  logic               err_q;
  logic               last_word;
  logic               last_out;
  logic               wd_expired;

  // Bias slot (kaddr == KS) of the last kernel closes the load.
  assign last_word = (kaddr_q == KW'(KS)) && (conv_q == CW'(N_CONVOLUTIONS - 1));
  assign last_out  = (out_cnt_q == OW'(OUT_PER_FRAME - 1));

`ifdef CONV_CTRL_TIMEOUT_EN
  handshake_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .active_i  (state_q == eRUN),
    .clear_i   (layer_out_hs_i || (state_q == eSTART)),
    .expired_o (wd_expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  assign timeout_o = wd_expired;
  assign loaded_o  = loaded_q;
  assign err_o     = err_q;
  // Load completion pulses from a register; run completion from eDONE.
  assign done_o    = load_done_q || (state_q == eDONE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cfg_yumi_o       = 1'b0;
    layer_wen_o      = 1'b0;
    layer_mem_data_o = '0;
    layer_mem_addr_o = '0;
    layer_start_o    = 1'b0;
    busy_o           = (state_q != eIDLE);
    case (state_q)
      eIDLE: begin
        if (load_i) begin
          state_d = eLOAD;
        end else if (run_i && loaded_q) begin
          state_d = eSTART;
        end
      end
      eLOAD: begin
        cfg_yumi_o       = cfg_valid_i;
        layer_mem_addr_o = {conv_q + CW'(1), kaddr_q};
        if (cfg_valid_i) begin
          layer_wen_o      = 1'b1;
          layer_mem_data_o = cfg_data_i;
          if (last_word) begin
            state_d = eIDLE;
          end
        end
      end
      eSTART: begin
        layer_start_o = 1'b1;
        state_d       = eRUN;
      end
      eRUN: begin
        if (layer_out_hs_i && last_out) begin
          state_d = (frames_left_q == FRAME_W'(1)) ? eDONE : eSTART;
        end else if (wd_expired) begin
          state_d = eIDLE;
        end
      end
      eDONE: begin
        state_d = eIDLE;
      end
      default: begin
        state_d = eIDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      conv_q        <= '0;
      kaddr_q       <= '0;
      out_cnt_q     <= '0;
      frames_left_q <= '0;
      loaded_q      <= 1'b0;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        eIDLE: begin
          if (load_i) begin
            loaded_q <= 1'b0;
            conv_q   <= '0;
            kaddr_q  <= '0;
          end else if (run_i) begin
            if (loaded_q) begin
              frames_left_q <= (run_frames_i == '0) ? FRAME_W'(1) : run_frames_i;
              out_cnt_q     <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        eLOAD: begin
          if (cfg_valid_i) begin
            if (kaddr_q == KW'(KS)) begin
              kaddr_q <= '0;
              if (last_word) begin
                loaded_q    <= 1'b1;
                load_done_q <= 1'b1;
              end else begin
                conv_q <= conv_q + CW'(1);
              end
            end else begin
              kaddr_q <= kaddr_q + KW'(1);
            end
          end
        end
        eRUN: begin
          if (layer_out_hs_i) begin
            if (last_out) begin
              out_cnt_q     <= '0;
              frames_left_q <= frames_left_q - FRAME_W'(1);
            end else begin
              out_cnt_q <= out_cnt_q + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb/tb_conv_layer_ctrl.sv - randomized self-checking bench for conv_layer_ctrl
module tb_conv_layer_ctrl;

  localparam int N    = 2;
  localparam int KH   = 3;
  localparam int KWD  = 2;
  localparam int IH   = 5;
  localparam int WS   = 16;
  localparam int FW   = 8;
  localparam int TO   = 16;
  localparam int KS   = KH * KWD;
  localparam int OPF  = IH - KH + 1;
  localparam int CWB  = $clog2(N + 1);
  localparam int KWB  = $clog2(KS + 1);
  localparam int AWB  = CWB + KWB;
  localparam int TOTAL_WORDS = N * (KS + 1);

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           load_i;
  logic           run_i;
  logic [FW-1:0]  run_frames_i;
  logic           cfg_valid_i;
  logic           cfg_yumi_o;
  logic [WS-1:0]  cfg_data_i;
  logic           layer_start_o;
  logic [AWB-1:0] layer_mem_addr_o;
  logic           layer_wen_o;
  logic [WS-1:0]  layer_mem_data_o;
  logic           layer_out_hs_i;
  logic           loaded_o;
  logic           busy_o;
  logic           done_o;
  logic           err_o;
  logic           timeout_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  conv_layer_ctrl #(
    .N_CONVOLUTIONS     (N),
    .KERNEL_HEIGHT      (KH),
    .KERNEL_WIDTH       (KWD),
    .INPUT_LAYER_HEIGHT (IH),
    .WORD_SIZE          (WS),
    .FRAME_W            (FW),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .load_i           (load_i),
    .run_i            (run_i),
    .run_frames_i     (run_frames_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_yumi_o       (cfg_yumi_o),
    .cfg_data_i       (cfg_data_i),
    .layer_start_o    (layer_start_o),
    .layer_mem_addr_o (layer_mem_addr_o),
    .layer_wen_o      (layer_wen_o),
    .layer_mem_data_o (layer_mem_data_o),
    .layer_out_hs_i   (layer_out_hs_i),
    .loaded_o         (loaded_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    load_i         = 1'b0;
    run_i          = 1'b0;
    run_frames_i   = '0;
    cfg_valid_i    = 1'b0;
    cfg_data_i     = '0;
    layer_out_hs_i = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
  task automatic do_load(input string tag, input bit seq_data, input int mode, input bit with_run);
    logic [WS-1:0]  words[$];
    logic [AWB-1:0] addrs[$];
    int idx = 0, wens = 0, bad = 0, dones = 0, starts = 0, cyc = 0;
    int last_hs_cyc = -1, done_cyc = -1;
    bit v;
    for (int c = 1; c <= N; c++)
      for (int k = 0; k <= KS; k++) begin
        words.push_back(seq_data ? WS'(words.size() + 1) : WS'($urandom));
        addrs.push_back(AWB'((c << KWB) | k));
      end
    @(negedge clk_i);
    idle_inputs();
    load_i = 1'b1;
    run_i  = with_run;
    run_frames_i = FW'(1);
    @(negedge clk_i);
    idle_inputs();
    #2;
    check({tag, "_enter_loaded"}, loaded_o, 0);
    check({tag, "_enter_busy"}, busy_o, 1);
    if (layer_start_o) starts++;
    while (dones == 0 && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (idx >= TOTAL_WORDS) v = 1'b0;
      cfg_valid_i = v;
      cfg_data_i  = (v && idx < TOTAL_WORDS) ? words[idx] : WS'($urandom);
      #2;
      if (cfg_yumi_o !== v || layer_wen_o !== v) bad++;
      if (layer_start_o) starts++;
      if (layer_wen_o) begin
        wens++;
        if (idx < TOTAL_WORDS) begin
          if (layer_mem_addr_o !== addrs[idx] || layer_mem_data_o !== words[idx]) bad++;
          idx++;
          if (idx == TOTAL_WORDS) last_hs_cyc = cyc;
        end else bad++;
      end
      if (done_o) begin
        dones++;
        done_cyc = cyc;
        check({tag, "_loaded_at_done"}, loaded_o, 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      cfg_valid_i = 1'b1;
      #2;
      if (layer_wen_o) wens++;
      if (done_o) dones++;
      if (layer_start_o) starts++;
    end
    idle_inputs();
    check({tag, "_wen_count"}, wens, TOTAL_WORDS);
    check({tag, "_stream_errs"}, bad, 0);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
    check({tag, "_no_start"}, starts, 0);
    check({tag, "_loaded"}, loaded_o, 1);
    check({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic do_run(input string tag, input int frames_in);
    int frames = (frames_in == 0) ? 1 : frames_in;
    int starts = 0, dones = 0, hs_total = 0, frame_hs = 0, frames_done = 0, bad = 0, cyc = 0;
    bit exp_start, exp_done, in_frame, hs;
    @(negedge clk_i);
    idle_inputs();
    run_i        = 1'b1;
    run_frames_i = FW'(frames_in);
    #2;
    if (layer_start_o || done_o || busy_o) bad++;
    exp_start = 1'b1;
    exp_done  = 1'b0;
    in_frame  = 1'b0;
    while (dones == 0 && cyc < 500) begin
      @(negedge clk_i);
      cyc++;
      hs             = in_frame && ($urandom_range(0, 3) != 0);
      layer_out_hs_i = hs;
      load_i         = ($urandom_range(0, 3) == 0);
      run_i          = ($urandom_range(0, 3) == 0);
      cfg_valid_i    = $urandom_range(0, 1);
      run_frames_i   = FW'($urandom);
      #2;
      if (layer_start_o !== exp_start || done_o !== exp_done) bad++;
      if (busy_o !== 1'b1 || layer_wen_o || cfg_yumi_o || timeout_o) bad++;
      if (layer_start_o) begin
        starts++;
        in_frame = 1'b1;
      end
      if (done_o) dones++;
      exp_start = 1'b0;
      exp_done  = 1'b0;
      if (hs) begin
        hs_total++;
        frame_hs++;
        if (frame_hs == OPF) begin
          frame_hs = 0;
          in_frame = 1'b0;
          frames_done++;
          if (frames_done == frames) exp_done = 1'b1;
          else exp_start = 1'b1;
        end
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #2;
    if (busy_o || done_o || layer_start_o) bad++;
    check({tag, "_starts"}, starts, frames);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_handshakes"}, hs_total, OPF * frames);
    check({tag, "_timing_errs"}, bad, 0);
    check({tag, "_loaded_kept"}, loaded_o, 1);
  endtask

  task automatic do_err_run(input string tag);
    int errs = 0, starts = 0, err_cyc = -1;
    @(negedge clk_i);
    idle_inputs();
    run_i = 1'b1;
    run_frames_i = FW'(2);
    #2;
    if (err_o) errs++;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i);
      idle_inputs();
      #2;
      if (err_o) begin
        errs++;
        err_cyc = i;
      end
      if (layer_start_o || busy_o) starts++;
    end
    check({tag, "_err_pulses"}, errs, 1);
    check({tag, "_err_latency"}, err_cyc, 1);
    check({tag, "_no_start"}, starts, 0);
  endtask

  task automatic do_reset_mid_load();
    int hs_cnt = 0, wens_after = 0;
    @(negedge clk_i);
    idle_inputs();
    load_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    while (hs_cnt < 5) begin
      @(negedge clk_i);
      cfg_valid_i = 1'b1;
      cfg_data_i  = WS'(hs_cnt + 16'h100);
      #2;
      if (layer_wen_o) hs_cnt++;
      if (hs_cnt == 0 && !busy_o) break;
    end
    check("rst_mid_load_reached", hs_cnt, 5);
    reset_i = 1'b1;
    #1;
    check("rst_mid_load_wen", layer_wen_o, 0);
    check("rst_mid_load_loaded", loaded_o, 0);
    check("rst_mid_load_idle", busy_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      cfg_valid_i = 1'b1;
      #2;
      if (layer_wen_o || layer_start_o || cfg_yumi_o) wens_after++;
    end
    idle_inputs();
    check("rst_mid_load_quiet", wens_after, 0);
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    #2;
    check("reset_outputs",
          {cfg_yumi_o, layer_start_o, layer_wen_o, loaded_o, busy_o, done_o, err_o, timeout_o},
          8'h00);
    check("reset_addr", layer_mem_addr_o, 0);
    check("reset_data", layer_mem_data_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    do_err_run("err_before_load");
    do_load("load_seq_toggle", 1'b1, 1, 1'b0);
    do_run("run3", 3);
    do_load("load_rand", 1'b0, 2, 1'b0);
    do_run("run0", 0);
    do_run("run_rand", $urandom_range(1, 4));
    do_load("load_with_run", 1'b0, 0, 1'b1);
    do_run("run2", 2);

`ifdef CONV_CTRL_TIMEOUT_EN
    begin
      int cyc = -1, tos = 0;
      @(negedge clk_i);
      idle_inputs();
      run_i = 1'b1;
      run_frames_i = FW'(1);
      for (int i = 0; i < 100 && tos == 0; i++) begin
        @(negedge clk_i);
        idle_inputs();
        #2;
        if (layer_start_o) cyc = 0;
        else if (cyc >= 0) cyc++;
        if (timeout_o) tos++;
      end
      check("timeout_cycle", cyc, TO);
      @(negedge clk_i);
      #2;
      check("timeout_idle", busy_o, 0);
      check("timeout_loaded_kept", loaded_o, 1);
      check("timeout_no_done", done_o, 0);
    end
`else
    begin
      int tos = 0, dn = 0;
      @(negedge clk_i);
      idle_inputs();
      run_i = 1'b1;
      run_frames_i = FW'(1);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        idle_inputs();
        #2;
        if (timeout_o) tos++;
      end
      check("no_watchdog_timeout", tos, 0);
      check("no_watchdog_busy", busy_o, 1);
      for (int i = 0; i < OPF; i++) begin
        @(negedge clk_i);
        layer_out_hs_i = 1'b1;
      end
      @(negedge clk_i);
      idle_inputs();
      #2;
      if (done_o) dn++;
      check("no_watchdog_done", dn, 1);
    end
`endif

    do_reset_mid_load();
    do_err_run("err_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
